popcount_decoder: RTL and testbench
===================================

// Module: popcount_decoder
// PURPOSE
//  Inverse of the 7-bit ones-counting encoder. Takes a 3-bit ones count and
//  builds a 7-bit word holding exactly that many ones, thermometer style.
//  The word is presented in parallel, then shifted out serially LSB-first
//  with framing strobes. At frame end, a self-check flag compares the ones
//  counted on the serial stream with the requested count.
//  Sits upstream of encoder/mux: a popcount_decoder -> encoder loop is
//  identity on the count.
// PARAMETERS
//  WIDTH  7  word width; number of serial bits per frame
//  CW     3  count width; must satisfy 2**CW-1 >= WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept (state IDLE)
//  in_count   in   CW     requested number of ones, 0..WIDTH
//  in_mode    in   1      0: ones in low bits; 1: ones in high bits
//  word_out   out  WIDTH  generated word, held until next accept
//  ser_out    out  1      serial data, LSB first
//  ser_valid  out  1      ser_out valid (SHIFT state)
//  ser_last   out  1      marks final serial bit of frame
//  done       out  1      one-cycle pulse after final bit
//  match      out  1      ones seen on ser_out == latched count; valid from done
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; all outputs 0, including in_ready
//   (in_ready=0 while rst=1); shift reg, bit index, ones counter, latched count 0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept on the edge where in_valid&&in_ready.
//   On that edge:
//   - latch count;
//   - word_out = mode0 ? (1<<n)-1 : ((1<<n)-1)<<(WIDTH-n), for n=in_count;
//   - shift reg = same word; idx=0; ones=0;
//   - match cleared; go to SHIFT.
//   n=0 -> all zeros. n=WIDTH -> all ones (either mode).
//   n>WIDTH is unreachable for default params; if it occurs, saturate n to WIDTH.
//  SHIFT: in_ready=0, ser_valid=1, ser_out=shreg[0], ser_last=(idx==WIDTH-1).
//   Each edge: shreg>>=1, ones+=ser_out, idx++.
//   Edge with idx==WIDTH-1 -> DONE.
//  DONE: one cycle; done=1; match=(ones==latched count), registered.
//   Next edge -> IDLE.
//  Timing: accept at edge e0 -> bit k on ser_out during cycle after e0+k,
//   k=0..WIDTH-1; done during cycle after e0+WIDTH; in_ready=1 after e0+WIDTH+1.
//   Earliest next accept e0+WIDTH+2 (9-cycle frame period for WIDTH=7).
//  in_valid/in_count/in_mode ignored outside IDLE; changes mid-frame have no effect.
//  word_out and match hold their values through IDLE until the next accept.
//  rst mid-frame: frame dropped immediately; ser_valid/ser_last/done go 0
//   with no done pulse; the next frame after release starts clean.
//  Arithmetic: ones counter is CW bits and cannot overflow (max WIDTH).
// TESTING
//  1 Reset: rst=1 -> all outputs 0, in_ready=0; rst=0 -> in_ready=1 next cycle.
//  2 count=3, mode=0 -> word_out=7'b0000111; ser_out 1,1,1,0,0,0,0;
//    ser_last on 7th bit; then done=1, match=1.
//  3 count=3, mode=1 -> word_out=7'b1110000; ser_out 0,0,0,0,1,1,1; match=1.
//  4 count=0 and count=7, both modes -> 7'b0000000 / 7'b1111111; match=1 each.
//  5 in_valid held high, count 5 then 2: accepts exactly 9 cycles apart;
//    in_count toggling during SHIFT has no effect on ser_out.
//  6 rst pulse during SHIFT bit 3 -> ser_valid=0 at once, no done;
//    next count=6 frame gives word_out=7'b0111111, match=1.
//  All: word_out fed to encoder gives y==count for all 16 count/mode combos.

Source files
------------

// File: rtl/popcount_decoder_if.sv
// Request/response bundle for popcount_decoder: count request in, word and serial frame out.
interface popcount_decoder_if #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned CW    = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_count;
    logic             in_mode;
    logic [WIDTH-1:0] word_out;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             done;
    logic             match;

    // Requester side: drives the count request, observes word and serial frame
    modport master (
        output in_valid,
        output in_count,
        output in_mode,
        input  in_ready,
        input  word_out,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  done,
        input  match
    );

    // Decoder side
    modport slave (
        input  in_valid,
        input  in_count,
        input  in_mode,
        output in_ready,
        output word_out,
        output ser_out,
        output ser_valid,
        output ser_last,
        output done,
        output match
    );
endinterface

// File: rtl/popcount_decoder.sv
// popcount_decoder: turns a ones count into a thermometer word, shifts it out
// LSB-first with framing strobes, and self-checks the serial ones count.
module popcount_decoder #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned CW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    popcount_decoder_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned LAST_IDX = WIDTH - 1;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [WIDTH-1:0] word_q,      word_d;
    logic [CW-1:0]    idx_q,       idx_d;
    logic [CW-1:0]    ones_q,      ones_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             in_ready_q,  in_ready_d;
    logic             ser_out_q,   ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q,  ser_last_d;
    logic             done_q,      done_d;
    logic             match_q,     match_d;

    logic             accept_c;
    logic [CW-1:0]    n_sat_c;
    logic [WIDTH-1:0] gen_word_c;
    logic [CW-1:0]    ones_inc_c;

    // Requested count clamped to the word width
    always_comb begin
        n_sat_c = bus.in_count;
        if (bus.in_count > CW'(WIDTH)) begin
            n_sat_c = CW'(WIDTH);
        end
    end

    // Thermometer word: n ones packed low (mode 0) or high (mode 1)
    always_comb begin
        gen_word_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (bus.in_mode) begin
                gen_word_c[i] = (i >= (int'(WIDTH) - int'(n_sat_c)));
            end else begin
                gen_word_c[i] = (i < int'(n_sat_c));
            end
        end
    end

    assign accept_c   = bus.in_valid && in_ready_q;
    assign ones_inc_c = ones_q + CW'(shreg_q[0]);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        word_d      = word_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        done_d      = 1'b0;
        match_d     = match_q;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (accept_c) begin
                    count_d     = n_sat_c;
                    word_d      = gen_word_c;
                    shreg_d     = gen_word_c;
                    idx_d       = '0;
                    ones_d      = '0;
                    match_d     = 1'b0;
                    in_ready_d  = 1'b0;
                    ser_valid_d = 1'b1;
                    ser_out_d   = gen_word_c[0];
                    ser_last_d  = (idx_d == CW'(LAST_IDX));
                    state_d     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ones_d  = ones_inc_c;
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + CW'(1);
                if (idx_q == CW'(LAST_IDX)) begin
                    done_d  = 1'b1;
                    match_d = (ones_inc_c == count_q);
                    state_d = ST_DONE;
                end else begin
                    ser_valid_d = 1'b1;
                    ser_out_d   = shreg_d[0];
                    ser_last_d  = (idx_d == CW'(LAST_IDX));
                end
            end

            ST_DONE: begin
                in_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                in_ready_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            ones_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            done_q      <= done_d;
            match_q     <= match_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.word_out  = word_q;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.done      = done_q;
    assign bus.match     = match_q;

endmodule

// File: tb/tb_popcount_decoder.sv
// Scoreboard bench for popcount_decoder: driver pushes expected frames, monitor checks them.
module tb_popcount_decoder;

    localparam int unsigned WIDTH = 7;
    localparam int unsigned CW    = 3;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               count;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    popcount_decoder_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    popcount_decoder #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   frames     = 0;
    int   sent       = 0;
    int   aborted    = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference word: n ones at the bottom, or the same block moved to the top
    function automatic logic [WIDTH-1:0] model(input int n, input bit m);
        int v;
        v = (1 << n) - 1;
        if (m) v = v << (WIDTH - n);
        return WIDTH'(v);
    endfunction

    // Issue one request (called at a negedge); returns the accept time
    task automatic send(input int n, input bit m, input bit hold, output time t_acc);
        int   w;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_count = CW'(n);
        bus.in_mode  = m;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            t_acc = 0;
            return;
        end
        e.word  = model(n, m);
        e.count = n;
        q.push_back(e);
        sent++;
        @(posedge clk);
        t_acc = $time;
        #1;
        if (!hold) bus.in_valid = 1'b0;
        bus.in_count = CW'($urandom_range(0, 7));
        bus.in_mode  = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("first_bit_latency", int'(bus.ser_valid), 1);
    endtask

    // Monitor: walks each serial frame against the head of the scoreboard
    initial begin : monitor
        int               bit_i;
        int               ones;
        bit               in_frame;
        bit               after_done;
        exp_t             cur;
        logic [WIDTH-1:0] last_word;
        bit_i = 0; ones = 0; in_frame = 0; after_done = 0; last_word = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (in_frame) begin
                    q.delete(0);
                    aborted++;
                end
                in_frame   = 0;
                after_done = 0;
                bit_i      = 0;
                continue;
            end
            if (after_done) begin
                chk("done_one_cycle", int'(bus.done), 0);
                chk("in_ready_after_done", int'(bus.in_ready), 1);
                chk("word_held", int'(bus.word_out), int'(last_word));
                chk("match_held", int'(bus.match), 1);
                after_done = 0;
            end
            if (bus.ser_valid) begin
                if (!in_frame) begin
                    if (q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                        continue;
                    end
                    cur      = q[0];
                    in_frame = 1;
                    bit_i    = 0;
                    ones     = 0;
                    chk("word_out", int'(bus.word_out), int'(cur.word));
                    chk("match_cleared", int'(bus.match), 0);
                end
                if (bit_i >= int'(WIDTH)) begin
                    chk("frame_too_long", bit_i, int'(WIDTH) - 1);
                end else begin
                    chk("ser_out", int'(bus.ser_out), int'(cur.word[bit_i]));
                    chk("ser_last", int'(bus.ser_last), int'(bit_i == int'(WIDTH) - 1));
                end
                ones += int'(bus.ser_out);
                bit_i++;
            end
            if (bus.done) begin
                if (!in_frame) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    chk("bits_in_frame", bit_i, int'(WIDTH));
                    chk("ser_ones", ones, cur.count);
                    chk("match", int'(bus.match), 1);
                    chk("encoder_loop", $countones(bus.word_out), cur.count);
                    q.delete(0);
                    in_frame   = 0;
                    after_done = 1;
                    last_word  = cur.word;
                    frames++;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin : driver
        time t1, t2, tx;
        int  w;
        bus.in_valid = 1'b0;
        bus.in_count = '0;
        bus.in_mode  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_ser_valid", int'(bus.ser_valid), 0);
        chk("rst_word_out", int'(bus.word_out), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_match", int'(bus.match), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_release", int'(bus.in_ready), 1);

        // Every count/mode combination
        for (int n = 0; n <= int'(WIDTH); n++) begin
            for (int m = 0; m < 2; m++) begin
                send(n, 1'(m), 1'b0, tx);
            end
        end

        // Held in_valid: 5 then 2, input churn during SHIFT ignored
        send(5, 1'b0, 1'b1, t1);
        repeat (4) begin
            @(negedge clk);
            bus.in_count = CW'($urandom_range(0, 7));
            bus.in_mode  = 1'($urandom_range(0, 1));
        end
        send(2, 1'b0, 1'b0, t2);
        chk("accept_spacing", int'((t2 - t1) / 10), int'(WIDTH) + 2);

        // Reset during bit 3 of a frame
        send(4, 1'b1, 1'b0, tx);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ser_valid", int'(bus.ser_valid), 0);
        chk("midrst_ser_last", int'(bus.ser_last), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        chk("midrst_word_out", int'(bus.word_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_midrst", int'(bus.in_ready), 1);
        send(6, 1'b0, 1'b0, tx);

        // Random traffic with random idle gaps
        repeat (24) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, tx);
        end

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("frames_done", frames, sent - 1);
        chk("frames_aborted", aborted, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
